seg_scan_ctrl: RTL

Time-multiplexed scan controller for a multi-digit 7-segment display. It drives the select input and enable of the shared 4-to-16 decoder (`dec416`) so that one digit-select line is active at a time. It inserts a blanking gap between digits to prevent ghosting, skips masked-off digits, and flags each completed frame. It sits between the display-data registers and the `dec416` instance in the display top level.

---
 rtl/seg_scan_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed digit scanner feeding a shared dec416.
// Each enabled digit gets a blanking gap followed by a dwell window. Masked
// digits are skipped, and frame_done marks the wrap back to the lowest digit.
//
// state | meaning
// IDLE  | decoder disabled, waiting for run with a non-empty mask
// BLANK | decoder disabled, dec_in already holds the upcoming digit
// SHOW  | decoder enabled on dec_in for the dwell window
module seg_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int DWELL_CYCLES = 1000,
   parameter int BLANK_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   input  logic [15:0] digit_mask,
   output logic [3:0]  dec_in,
   output logic        dec_enable,
   output logic        frame_done,
   output logic        busy
);

   localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int CW      = $clog2(MAX_CYC + 1);

   localparam logic [15:0]   valid_mask = 16'((32'd1 << NUM_DIGITS) - 32'd1);
   localparam logic [CW-1:0] blank_last = CW'(BLANK_CYCLES - 1);
   localparam logic [CW-1:0] dwell_last = CW'(DWELL_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [3:0]    dec_in_n;
   logic          dec_enable_n;
   logic          frame_done_n;
   logic          busy_n;

   logic [15:0]   eff_mask;
   logic [3:0]    first_idx;
   logic [3:0]    next_idx;
   logic          wrap;
   int            scan_idx;

   assign eff_mask = digit_mask & valid_mask;

   // Lowest active digit, and the next active digit after dec_in (cyclic).
   // Loops run downward so the nearest candidate is the last one assigned.
   always_comb begin
      first_idx = 4'd0;
      next_idx  = dec_in;
      scan_idx  = 0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         if (eff_mask[4'(i)]) first_idx = 4'(i);
      end
      for (int k = NUM_DIGITS; k >= 1; k--) begin
         scan_idx = int'(dec_in) + k;
         if (scan_idx >= NUM_DIGITS) scan_idx = scan_idx - NUM_DIGITS;
         if (eff_mask[4'(scan_idx)]) next_idx = 4'(scan_idx);
      end
      wrap = (next_idx <= dec_in);
   end

   // Next-state and next-output decode; run dropping beats counter expiry.
   always_comb begin
      state_n      = state;
      cnt_n        = cnt;
      dec_in_n     = dec_in;
      dec_enable_n = 1'b0;
      frame_done_n = 1'b0;
      case (state)
         IDLE: begin
            if (run && (eff_mask != 16'd0)) begin
               dec_in_n = first_idx;
               cnt_n    = '0;
               state_n  = BLANK;
            end
         end
         BLANK: begin
            if (!run) begin
               cnt_n   = '0;
               state_n = IDLE;
            end else if (cnt == blank_last) begin
               cnt_n        = '0;
               state_n      = SHOW;
               dec_enable_n = 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         SHOW: begin
            if (!run) begin
               cnt_n   = '0;
               state_n = IDLE;
            end else if (cnt == dwell_last) begin
               cnt_n = '0;
               if (eff_mask == 16'd0) begin
                  state_n = IDLE;
               end else begin
                  state_n      = BLANK;
                  dec_in_n     = next_idx;
                  frame_done_n = wrap;
               end
            end else begin
               cnt_n        = cnt + 1'b1;
               dec_enable_n = 1'b1;
            end
         end
         default: begin
            cnt_n   = '0;
            state_n = IDLE;
         end
      endcase
      busy_n = (state_n != IDLE);
   end

   // State, counter and registered outputs; reset clears everything at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         dec_in     <= 4'd0;
         dec_enable <= 1'b0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         dec_in     <= dec_in_n;
         dec_enable <= dec_enable_n;
         frame_done <= frame_done_n;
         busy       <= busy_n;
      end
   end

endmodule
